// File: rtl/gpr_write_buffer.sv
// In-order write-back buffer in front of the register-file write port, with rs1 bypass and pending bitmap.
// Entries reach the write port one cycle after acceptance; o_wbReady drops only when every slot is occupied.
module gpr_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_resetn,
    input  logic                     i_wbValid,
    output logic                     o_wbReady,
    input  logic [4:0]               i_wbAddr,
    input  logic [31:0]              i_wbData,
    input  logic                     i_gprStall,
    output logic                     o_gprWe,
    output logic [4:0]               o_gprWaddr,
    output logic [31:0]              o_gprWdata,
    input  logic [4:0]               i_rs1Addr,
    output logic                     o_rs1Hit,
    output logic [31:0]              o_rs1Data,
    output logic [31:0]              o_pending,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [4:0]    addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic          not_empty;

    // Age-ordered view of the ring: slot_idx[0] is the head (oldest).
    logic [AW-1:0] slot_idx  [DEPTH];
    logic          slot_live [DEPTH];

    assign not_empty = (count_q != '0);

    // Readiness comes from registered occupancy only, so a pop in the
    // same cycle never frees a slot early.
    assign o_wbReady = i_resetn & (count_q < CW'(DEPTH));
    assign accept    = i_wbValid & o_wbReady;
    assign push      = accept & (i_wbAddr != 5'd0);

    assign o_gprWe   = i_resetn & not_empty & ~i_gprStall;
    assign pop       = o_gprWe;

    assign o_gprWaddr = not_empty ? addr_q[head_q] : 5'd0;
    assign o_gprWdata = not_empty ? data_q[head_q] : 32'd0;
    assign o_count    = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + AW'(1);
        end
        if (push) begin
            tail_d = tail_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is never cleared; liveness is derived from head/count.
    always_ff @(posedge i_clk) begin
        if (push) begin
            addr_q[tail_q] <= i_wbAddr;
            data_q[tail_q] <= i_wbData;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        assign slot_idx[k]  = head_q + AW'(k);
        assign slot_live[k] = (CW'(k) < count_q);
    end

    // Walk oldest to youngest so the last match is the youngest write.
    always_comb begin
        o_rs1Hit  = 1'b0;
        o_rs1Data = 32'd0;
        o_pending = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_live[k]) begin
                o_pending[addr_q[slot_idx[k]]] = 1'b1;
                if ((i_rs1Addr != 5'd0) && (addr_q[slot_idx[k]] == i_rs1Addr)) begin
                    o_rs1Hit  = 1'b1;
                    o_rs1Data = data_q[slot_idx[k]];
                end
            end
        end
        o_pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_gpr_write_buffer.sv
// Bench for gpr_write_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_gpr_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        wb_vld;
    logic [4:0]  wb_addr;
    logic [31:0] wb_dat;
    logic        stall;
    logic [4:0]  rs1;

    logic        wb_rdy;
    logic        gpr_we;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        rs1_hit;
    logic [31:0] rs1_dat;
    logic [31:0] pending;
    logic [$clog2(DEPTH):0] count;

    gpr_write_buffer #(.DEPTH(DEPTH)) dut (
        .i_clk      (clk),
        .i_resetn   (resetn),
        .i_wbValid  (wb_vld),
        .o_wbReady  (wb_rdy),
        .i_wbAddr   (wb_addr),
        .i_wbData   (wb_dat),
        .i_gprStall (stall),
        .o_gprWe    (gpr_we),
        .o_gprWaddr (gpr_waddr),
        .o_gprWdata (gpr_wdata),
        .i_rs1Addr  (rs1),
        .o_rs1Hit   (rs1_hit),
        .o_rs1Data  (rs1_dat),
        .o_pending  (pending),
        .o_count    (count)
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   armed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: accepted non-x0 writes queue up; the oldest retires
    // on any edge where the port is free and something is queued.
    initial begin
        ent_t e;
        bit   do_pop;
        bit   do_push;
        forever begin
            @(posedge clk);
            if (!resetn) begin
                exp_q.delete();
                armed = 1;
            end else begin
                do_pop  = (exp_q.size() != 0) && !stall;
                do_push = wb_vld && (exp_q.size() < DEPTH) && (wb_addr != 5'd0);
                if (do_pop) void'(exp_q.pop_front());
                if (do_push) begin
                    e.a = wb_addr;
                    e.d = wb_dat;
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Monitor: on every falling edge compare all outputs against the model.
    initial begin
        int          n;
        logic [31:0] p;
        logic        h;
        logic [31:0] hd;
        forever begin
            @(negedge clk);
            if (armed) begin
                n  = exp_q.size();
                p  = 32'd0;
                h  = 1'b0;
                hd = 32'd0;
                for (int i = 0; i < n; i++) begin
                    p[exp_q[i].a] = 1'b1;
                    if (rs1 != 5'd0 && exp_q[i].a == rs1) begin
                        h  = 1'b1;
                        hd = exp_q[i].d;
                    end
                end
                p[0] = 1'b0;
                chk("count", 32'(count), 32'(n));
                chk("wbReady", 32'(wb_rdy), 32'(resetn && n < DEPTH));
                chk("gprWe", 32'(gpr_we), 32'(resetn && n != 0 && !stall));
                if (gpr_we) begin
                    if (n == 0) begin
                        total++;
                        bad++;
                        $display("FAIL write_unexpected: got addr %0d want no write at %0t", gpr_waddr, $time);
                    end else begin
                        chk("write_addr", 32'(gpr_waddr), 32'(exp_q[0].a));
                        chk("write_data", gpr_wdata, exp_q[0].d);
                    end
                end else if (n == 0) begin
                    chk("empty_waddr", 32'(gpr_waddr), 32'd0);
                    chk("empty_wdata", gpr_wdata, 32'd0);
                end
                chk("pending", pending, p);
                chk("rs1Hit", 32'(rs1_hit), 32'(h));
                chk("rs1Data", rs1_dat, hd);
            end
        end
    end

    task automatic cyc(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic st, input logic [4:0] r, input logic rn);
        wb_vld  = v;
        wb_addr = a;
        wb_dat  = d;
        stall   = st;
        rs1     = r;
        resetn  = rn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(0, 5'd0, 32'd0, 0, 5'd0, 0);
        cyc(0, 5'd0, 32'd0, 0, 5'd0, 0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_wbReady", 32'(wb_rdy), 32'd0);
        chk("rst_gprWe", 32'(gpr_we), 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_rs1Hit", 32'(rs1_hit), 32'd0);
        chk("rst_waddr", 32'(gpr_waddr), 32'd0);

        // Single write retires the cycle after acceptance.
        cyc(1, 5'd5, 32'h1234_5678, 0, 5'd0, 1);
        chk("t1_we", 32'(gpr_we), 32'd1);
        chk("t1_waddr", 32'(gpr_waddr), 32'd5);
        chk("t1_wdata", gpr_wdata, 32'h1234_5678);
        cyc(0, 5'd0, 32'd0, 0, 5'd0, 1);
        chk("t1_count", 32'(count), 32'd0);

        // x0 is accepted and dropped.
        cyc(1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 1);
        chk("x0_count", 32'(count), 32'd0);
        chk("x0_we", 32'(gpr_we), 32'd0);
        chk("x0_pending", pending, 32'd0);

        // Fill under stall, then full-with-pop and push+pop cycles.
        for (int i = 1; i <= 4; i++) cyc(1, 5'(i), 32'(i * 32'h111), 1, 5'd0, 1);
        chk("full_count", 32'(count), 32'd4);
        chk("full_wbReady", 32'(wb_rdy), 32'd0);
        chk("full_pending", pending, 32'h0000_001E);
        cyc(1, 5'd6, 32'h66, 1, 5'd0, 1);
        cyc(1, 5'd6, 32'h66, 1, 5'd0, 1);
        chk("blocked_count", 32'(count), 32'd4);
        cyc(1, 5'd6, 32'h66, 0, 5'd0, 1);
        chk("pop_only_count", 32'(count), 32'd3);
        cyc(1, 5'd6, 32'h66, 0, 5'd0, 1);
        chk("push_pop_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) cyc(0, 5'd0, 32'd0, 0, 5'd0, 1);
        chk("drain_count", 32'(count), 32'd0);

        // Bypass returns the youngest of two writes to the same register.
        cyc(1, 5'd7, 32'hA, 1, 5'd7, 1);
        cyc(1, 5'd7, 32'hB, 1, 5'd7, 1);
        chk("byp_hit", 32'(rs1_hit), 32'd1);
        chk("byp_data", rs1_dat, 32'hB);
        cyc(0, 5'd0, 32'd0, 0, 5'd7, 1);
        cyc(0, 5'd0, 32'd0, 0, 5'd7, 1);
        chk("byp_gone", 32'(rs1_hit), 32'd0);
        chk("byp_gone_data", rs1_dat, 32'd0);

        // Reset with queued entries and an in-flight request.
        for (int i = 10; i <= 12; i++) cyc(1, 5'(i), 32'(i), 1, 5'd0, 1);
        chk("pre_rst_count", 32'(count), 32'd3);
        cyc(1, 5'd13, 32'd13, 1, 5'd0, 0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_we", 32'(gpr_we), 32'd0);
        chk("mid_rst_pending", pending, 32'd0);
        cyc(1, 5'd9, 32'h55, 0, 5'd9, 1);
        chk("post_rst_we", 32'(gpr_we), 32'd1);
        chk("post_rst_waddr", 32'(gpr_waddr), 32'd9);
        chk("post_rst_wdata", gpr_wdata, 32'h55);
        chk("post_rst_hit", 32'(rs1_hit), 32'd1);
        cyc(0, 5'd0, 32'd0, 0, 5'd0, 1);
        chk("post_rst_count", 32'(count), 32'd0);

        // Random traffic; small address range keeps bypass hits frequent.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 65,
                5'($urandom_range(0, 7)),
                $urandom,
                $urandom_range(0, 99) < 40,
                5'($urandom_range(0, 7)),
                $urandom_range(0, 199) != 0);
        end
        for (int i = 0; i < DEPTH + 2; i++) cyc(0, 5'd0, 32'd0, 0, 5'd0, 1);
        chk("final_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
